// File: rtl/ctrl_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_param
// Purpose  : Control-signal pipeline E -> M1..Mn -> W for a pipelined RV32I
//            core, with branch/jump resolution in Execute.
// Options  : CTRL_PIPE_PERF_EN builds retired/redirect performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe_param #(
    parameter int ALUCTRL_W   = 4,
    parameter int RESULTSRC_W = 2,
    parameter int MEM_STAGES  = 1
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_ValidD,
    input  logic                   i_RegWriteD,
    input  logic                   i_MemWriteD,
    input  logic                   i_JumpD,
    input  logic                   i_JalrD,
    input  logic                   i_BranchD,
    input  logic                   i_ALUSrcD,
    input  logic [RESULTSRC_W-1:0] i_ResultSrcD,
    input  logic [ALUCTRL_W-1:0]   i_ALUControlD,
    input  logic [2:0]             i_BranchTypeD,
    input  logic                   i_StallE,
    input  logic                   i_FlushE,
    input  logic                   i_ZeroE,
    input  logic                   i_LtE,
    input  logic                   i_LtuE,
    output logic                   o_PCSrcE,
    output logic                   o_PCTargetSelE,
    output logic                   o_IllegalBranchE,
    output logic                   o_ResultSrcE_0,
    output logic [ALUCTRL_W-1:0]   o_ALUControlE,
    output logic                   o_ALUSrcE,
    output logic                   o_MemWriteM,
    output logic                   o_RegWriteM,
    output logic                   o_LoadPendingM,
    output logic                   o_RegWriteW,
    output logic [RESULTSRC_W-1:0] o_ResultSrcW,
    output logic                   o_ValidW,
    output logic [31:0]            o_RetiredCount,
    output logic [31:0]            o_RedirectCount
);

    localparam logic [RESULTSRC_W-1:0] c_RESULT_LOAD = RESULTSRC_W'(1);
    localparam logic [2:0] c_BR_EQ  = 3'b000;
    localparam logic [2:0] c_BR_NE  = 3'b001;
    localparam logic [2:0] c_BR_LT  = 3'b100;
    localparam logic [2:0] c_BR_GE  = 3'b101;
    localparam logic [2:0] c_BR_LTU = 3'b110;
    localparam logic [2:0] c_BR_GEU = 3'b111;

    // Execute stage register
    logic                   r_validE;
    logic                   r_regWriteE;
    logic                   r_memWriteE;
    logic                   r_jumpE;
    logic                   r_jalrE;
    logic                   r_branchE;
    logic                   r_aluSrcE;
    logic [RESULTSRC_W-1:0] r_resultSrcE;
    logic [ALUCTRL_W-1:0]   r_aluControlE;
    logic [2:0]             r_branchTypeE;

    // Memory stages (index 0 is M1) and Writeback
    logic                   r_validM     [MEM_STAGES];
    logic                   r_regWriteM  [MEM_STAGES];
    logic [RESULTSRC_W-1:0] r_resultSrcM [MEM_STAGES];
    logic                   r_memWriteM1;
    logic                   r_validW;
    logic                   r_regWriteW;
    logic [RESULTSRC_W-1:0] r_resultSrcW;

    logic w_branchCond;
    logic w_pcSrcE;
    logic w_loadPendingM;

    // A D entry without a valid instruction is captured as an all-zero bubble.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_FlushE) begin
            r_validE      <= 1'b0;
            r_regWriteE   <= 1'b0;
            r_memWriteE   <= 1'b0;
            r_jumpE       <= 1'b0;
            r_jalrE       <= 1'b0;
            r_branchE     <= 1'b0;
            r_aluSrcE     <= 1'b0;
            r_resultSrcE  <= '0;
            r_aluControlE <= '0;
            r_branchTypeE <= '0;
        end else if (!i_StallE) begin
            r_validE      <= i_ValidD;
            r_regWriteE   <= i_RegWriteD & i_ValidD;
            r_memWriteE   <= i_MemWriteD & i_ValidD;
            r_jumpE       <= i_JumpD & i_ValidD;
            r_jalrE       <= i_JalrD & i_ValidD;
            r_branchE     <= i_BranchD & i_ValidD;
            r_aluSrcE     <= i_ALUSrcD & i_ValidD;
            r_resultSrcE  <= i_ResultSrcD & {RESULTSRC_W{i_ValidD}};
            r_aluControlE <= i_ALUControlD & {ALUCTRL_W{i_ValidD}};
            r_branchTypeE <= i_BranchTypeD & {3{i_ValidD}};
        end
    end

    // M1 takes a bubble while E is held so the stalled instruction is not duplicated.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_StallE || !r_validE) begin
            r_validM[0]     <= 1'b0;
            r_regWriteM[0]  <= 1'b0;
            r_resultSrcM[0] <= '0;
            r_memWriteM1    <= 1'b0;
        end else begin
            r_validM[0]     <= 1'b1;
            r_regWriteM[0]  <= r_regWriteE;
            r_resultSrcM[0] <= r_resultSrcE;
            r_memWriteM1    <= r_memWriteE;
        end

        for (int k = 1; k < MEM_STAGES; k++) begin
            if (i_Reset) begin
                r_validM[k]     <= 1'b0;
                r_regWriteM[k]  <= 1'b0;
                r_resultSrcM[k] <= '0;
            end else begin
                r_validM[k]     <= r_validM[k-1];
                r_regWriteM[k]  <= r_regWriteM[k-1];
                r_resultSrcM[k] <= r_resultSrcM[k-1];
            end
        end

        if (i_Reset) begin
            r_validW     <= 1'b0;
            r_regWriteW  <= 1'b0;
            r_resultSrcW <= '0;
        end else begin
            r_validW     <= r_validM[MEM_STAGES-1];
            r_regWriteW  <= r_regWriteM[MEM_STAGES-1];
            r_resultSrcW <= r_resultSrcM[MEM_STAGES-1];
        end
    end

    always_comb begin
        w_branchCond = 1'b0;
        case (r_branchTypeE)
            c_BR_EQ:  w_branchCond = i_ZeroE;
            c_BR_NE:  w_branchCond = !i_ZeroE;
            c_BR_LT:  w_branchCond = i_LtE;
            c_BR_GE:  w_branchCond = !i_LtE;
            c_BR_LTU: w_branchCond = i_LtuE;
            c_BR_GEU: w_branchCond = !i_LtuE;
            default:  w_branchCond = 1'b0;
        endcase
    end

    always_comb begin
        w_loadPendingM = 1'b0;
        for (int k = 0; k < MEM_STAGES; k++) begin
            w_loadPendingM = w_loadPendingM |
                             (r_validM[k] && (r_resultSrcM[k] == c_RESULT_LOAD));
        end
    end

    assign w_pcSrcE = r_validE & !i_StallE &
                      (r_jumpE | r_jalrE | (r_branchE & w_branchCond));

    assign o_PCSrcE         = w_pcSrcE;
    assign o_PCTargetSelE   = r_jalrE & r_validE;
    assign o_IllegalBranchE = r_validE & r_branchE & (r_branchTypeE[2:1] == 2'b01);
    assign o_ResultSrcE_0   = r_resultSrcE[0] & r_validE;
    assign o_ALUControlE    = r_aluControlE & {ALUCTRL_W{r_validE}};
    assign o_ALUSrcE        = r_aluSrcE & r_validE;
    assign o_MemWriteM      = r_memWriteM1 & r_validM[0];
    assign o_RegWriteM      = r_regWriteM[0] & r_validM[0];
    assign o_LoadPendingM   = w_loadPendingM;
    assign o_RegWriteW      = r_regWriteW & r_validW;
    assign o_ResultSrcW     = r_resultSrcW & {RESULTSRC_W{r_validW}};
    assign o_ValidW         = r_validW;

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] r_retiredCount;
    logic [31:0] r_redirectCount;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_retiredCount  <= '0;
            r_redirectCount <= '0;
        end else begin
            if (r_validW) begin
                r_retiredCount <= r_retiredCount + 32'd1;
            end
            if (w_pcSrcE) begin
                r_redirectCount <= r_redirectCount + 32'd1;
            end
        end
    end

    assign o_RetiredCount  = r_retiredCount;
    assign o_RedirectCount = r_redirectCount;
`else
    assign o_RetiredCount  = 32'd0;
    assign o_RedirectCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe_param
// Purpose  : Directed + random scoreboard bench for ctrl_pipe_param, MEM_STAGES=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_param;

    localparam int MS  = 3;
    localparam int LAT = MS + 1;   // pushes between M1 load decision and W

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vD, rwD, mwD, jD, jrD, brD, asD;
    logic [1:0] rsD;
    logic [3:0] aluD;
    logic [2:0] btD;
    logic       stallE, flushE, zE, ltE, ltuE;

    logic        pcSrc, tgtSel, illegal, rs0, aluSrcE, mwM, rwM, ldPend, rwW, vW;
    logic [3:0]  aluE;
    logic [1:0]  rsW;
    logic [31:0] retCnt, redCnt;

    ctrl_pipe_param #(.ALUCTRL_W(4), .RESULTSRC_W(2), .MEM_STAGES(MS)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_ValidD(vD),
        .i_RegWriteD(rwD), .i_MemWriteD(mwD), .i_JumpD(jD), .i_JalrD(jrD),
        .i_BranchD(brD), .i_ALUSrcD(asD), .i_ResultSrcD(rsD),
        .i_ALUControlD(aluD), .i_BranchTypeD(btD),
        .i_StallE(stallE), .i_FlushE(flushE),
        .i_ZeroE(zE), .i_LtE(ltE), .i_LtuE(ltuE),
        .o_PCSrcE(pcSrc), .o_PCTargetSelE(tgtSel), .o_IllegalBranchE(illegal),
        .o_ResultSrcE_0(rs0), .o_ALUControlE(aluE), .o_ALUSrcE(aluSrcE),
        .o_MemWriteM(mwM), .o_RegWriteM(rwM), .o_LoadPendingM(ldPend),
        .o_RegWriteW(rwW), .o_ResultSrcW(rsW), .o_ValidW(vW),
        .o_RetiredCount(retCnt), .o_RedirectCount(redCnt)
    );

    typedef struct packed {
        logic v, rw, mw, j, jr, br, as;
        logic [1:0] rs;
        logic [3:0] alu;
        logic [2:0] bt;
    } ectl_t;

    typedef struct packed {
        logic v, rw, mw;
        logic [1:0] rs;
    } mctl_t;

    ectl_t       eM;
    mctl_t       q[$];
    int          nVec = 0;
    int          nErr = 0;
    logic [31:0] mRet, mRed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic brCond(input logic [2:0] bt, input logic z, input logic lt, input logic ltu);
        case (bt)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic setD(input logic v, input logic rw, input logic mw, input logic j,
                        input logic jr, input logic br, input logic as,
                        input logic [1:0] rs, input logic [3:0] alu, input logic [2:0] bt);
        vD = v; rwD = rw; mwD = mw; jD = j; jrD = jr; brD = br; asD = as;
        rsD = rs; aluD = alu; btD = bt;
    endtask

    // Entered at posedge+1 with inputs applied; checks mid-cycle, advances the model.
    task automatic cycle();
        logic  expPc;
        logic  lp;
        mctl_t ld;
        mctl_t w;
        #3;
        expPc = eM.v & !stallE & (eM.j | eM.jr | (eM.br & brCond(eM.bt, zE, ltE, ltuE)));
        chk("pcSrcE", pcSrc, expPc);
        chk("pcTargetSelE", tgtSel, eM.v & eM.jr);
        chk("illegalBranchE", illegal, eM.v & eM.br & (eM.bt == 3'b010 || eM.bt == 3'b011));
        chk("resultSrcE_0", rs0, eM.v & eM.rs[0]);
        chk("aluControlE", aluE, eM.v ? eM.alu : 4'd0);
        chk("aluSrcE", aluSrcE, eM.v & eM.as);

        if (stallE || !eM.v) ld = '0;
        else                 ld = '{1'b1, eM.rw, eM.mw, eM.rs};
        q.push_back(ld);

        chk("regWriteM", rwM, q[LAT-1].rw);
        chk("memWriteM", mwM, q[LAT-1].mw);
        lp = 1'b0;
        for (int i = 1; i < LAT; i++) lp = lp | (q[i].v & (q[i].rs == 2'b01));
        chk("loadPendingM", ldPend, lp);

        w = q.pop_front();
        chk("validW", vW, w.v);
        chk("regWriteW", rwW, w.rw);
        chk("resultSrcW", rsW, w.rs);
`ifdef CTRL_PIPE_PERF_EN
        chk("retiredCount", retCnt, mRet);
        chk("redirectCount", redCnt, mRed);
        mRet = mRet + 32'(w.v);
        mRed = mRed + 32'(expPc);
`else
        chk("retiredCount", retCnt, 32'd0);
        chk("redirectCount", redCnt, 32'd0);
`endif
        if (rst) begin
            q.delete();
            for (int i = 0; i < LAT; i++) q.push_back('0);
            eM = '0; mRet = '0; mRed = '0;
        end else if (flushE) begin
            eM = '0;
        end else if (!stallE) begin
            if (vD) eM = '{vD, rwD, mwD, jD, jrD, brD, asD, rsD, aluD, btD};
            else    eM = '0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] bts [8];
        bts = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};

        rst = 1'b1; stallE = 1'b0; flushE = 1'b0; zE = 1'b0; ltE = 1'b0; ltuE = 1'b0;
        setD(1, 1, 1, 1, 1, 1, 1, 2'b01, 4'hF, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        eM = '0; mRet = '0; mRed = '0;
        for (int i = 0; i < LAT; i++) q.push_back('0);

        // Reset state, with a live instruction sitting in D
        chk("rst_validW", vW, 0);      chk("rst_regWriteW", rwW, 0);
        chk("rst_resultSrcW", rsW, 0); chk("rst_regWriteM", rwM, 0);
        chk("rst_memWriteM", mwM, 0);  chk("rst_loadPendingM", ldPend, 0);
        chk("rst_pcSrcE", pcSrc, 0);   chk("rst_pcTargetSelE", tgtSel, 0);
        chk("rst_aluControlE", aluE, 0); chk("rst_retired", retCnt, 0);
        rst = 1'b0;

        // ALU stream with an occasional bubble
        for (int i = 0; i < 8; i++) begin
            setD(i != 5, 1, 0, 0, 0, 0, 1'(i), 2'b00, 4'(i + 3), 3'b000);
            cycle();
        end
        // Load latency: pending in M1..M3, then a load writeback in W
        setD(1, 1, 0, 0, 0, 0, 1, 2'b01, 4'h0, 3'b000); cycle();
        setD(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 3'b000);
        repeat (6) cycle();
        setD(1, 0, 1, 0, 0, 0, 1, 2'b00, 4'h0, 3'b000); cycle();   // store

        // Reset mid-stream
        for (int i = 0; i < 4; i++) begin
            setD(1, 1, 0, 0, 0, 0, 0, 2'b10, 4'(i), 3'b000); cycle();
        end
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            setD(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h9, 3'b000); cycle();
        end

        // Branch matrix: every funct3 against every flag combination
        for (int b = 0; b < 8; b++) begin
            for (int f = 0; f <= 8; f++) begin
                setD(1, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0, bts[b]);
                {zE, ltE, ltuE} = 3'(f);
                cycle();
            end
        end

        // Taken BEQ held three cycles by stall
        zE = 1'b0; ltE = 1'b0; ltuE = 1'b0;
        setD(1, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0, 3'b000); cycle();
        setD(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'h2, 3'b000);
        zE = 1'b1; stallE = 1'b1;
        repeat (3) cycle();
        stallE = 1'b0; cycle();
        zE = 1'b0;

        // Flush together with stall, then stall on a bubble
        setD(1, 1, 0, 0, 0, 0, 1, 2'b00, 4'h5, 3'b000); cycle();
        stallE = 1'b1; flushE = 1'b1; cycle();
        stallE = 1'b0; flushE = 1'b0;
        setD(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 3'b000); cycle();
        stallE = 1'b1; repeat (2) cycle(); stallE = 1'b0;

        // JAL+JALR together resolves as JALR
        setD(1, 1, 0, 1, 1, 0, 1, 2'b10, 4'h0, 3'b000); cycle();
        setD(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 3'b000); cycle();
        repeat (LAT) cycle();

`ifdef CTRL_PIPE_PERF_EN
        force dut.r_retiredCount = 32'hFFFF_FFFF;
        force dut.r_redirectCount = 32'hFFFF_FFFF;
        #1;
        release dut.r_retiredCount;
        release dut.r_redirectCount;
        mRet = 32'hFFFF_FFFF; mRed = 32'hFFFF_FFFF;
        setD(1, 1, 0, 1, 0, 0, 0, 2'b00, 4'h0, 3'b000); cycle();
        setD(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 3'b000);
        repeat (LAT + 2) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
`endif

        // Ten valid instructions, two of them taken branches
        zE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 7) setD(1, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0, 3'b000);
            else                  setD(1, 1, 0, 0, 0, 0, 0, 2'b00, 4'(i), 3'b000);
            cycle();
        end
        zE = 1'b0;
        setD(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 3'b000);
        repeat (LAT + 2) cycle();
`ifdef CTRL_PIPE_PERF_EN
        chk("retired10", retCnt, 32'd10);
        chk("redirect2", redCnt, 32'd2);
`endif

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            setD(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                 2'($urandom), 4'($urandom), 3'($urandom));
            stallE = ($urandom_range(0, 3) == 0);
            flushE = ($urandom_range(0, 5) == 0);
            rst    = ($urandom_range(0, 39) == 0);
            {zE, ltE, ltuE} = 3'($urandom);
            cycle();
        end
        rst = 1'b0; stallE = 1'b0; flushE = 1'b0;
        setD(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 3'b000);
        repeat (LAT + 2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe_param.md
# ctrl_pipe_param

Parametrised control-signal pipeline for the pipelined RV32I core. It carries decoded control from Decode through Execute, a configurable number of Memory stages, and Writeback. Each stage has a valid bit; Execute supports stall and flush. Execute resolves all six RV32I branch conditions plus JAL/JALR redirects and feeds the hazard unit and data path.

## Interface
- ALUCTRL_W, 4, ALU control width
- RESULTSRC_W, 2, result-select width; encoding 01 = load
- MEM_STAGES, 1, number of Memory pipeline registers (M1..Mn); legal range 1..3
- i_Clk  in  1  clock
- i_Reset  in  1  synchronous, active-high reset
- i_ValidD  in  1  Decode holds a real instruction
- i_RegWriteD, i_MemWriteD, i_JumpD, i_JalrD, i_BranchD, i_ALUSrcD  in  1 each  decoded control
- i_ResultSrcD  in  RESULTSRC_W  decoded result select
- i_ALUControlD  in  ALUCTRL_W  decoded ALU op
- i_BranchTypeD  in  3  funct3 of the branch
- i_StallE  in  1  hold Execute register
- i_FlushE  in  1  bubble Execute register
- i_ZeroE, i_LtE, i_LtuE  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
- o_PCSrcE  out  1  redirect PC this cycle
- o_PCTargetSelE  out  1  0 = PC+imm, 1 = ALU result (JALR)
- o_IllegalBranchE  out  1  valid branch with funct3 010/011 in E
- o_ResultSrcE_0  out  1  ResultSrcE[0] & ValidE (load-use detect)
- o_ALUControlE  out  ALUCTRL_W ; o_ALUSrcE  out  1
- o_MemWriteM, o_RegWriteM  out  1  M1-stage controls, gated by ValidM1
- o_LoadPendingM  out  1  any valid M stage holds a load
- o_RegWriteW  out  1 ; o_ResultSrcW  out  RESULTSRC_W ; o_ValidW  out  1
- o_RetiredCount, o_RedirectCount  out  32 each  performance counters (see Configuration)

## Operation
- Stages: E, M1..M(MEM_STAGES), W. Each stage register holds valid plus the controls still needed downstream.
- E update priority: i_Reset > i_FlushE (all fields 0) > i_StallE (hold) > load from D. A D entry with i_ValidD=0 loads as a bubble (all 0).
- M1 update: loads a bubble when i_StallE=1 or ValidE=0. This prevents duplicating the held instruction. Otherwise M1 loads from E.
- M(k+1) loads from Mk, and W loads from M(MEM_STAGES), unconditionally every cycle.
- All control outputs are ANDed with their stage's valid bit. A bubble never writes the register file or memory.
- Branch condition by i_BranchTypeD latched into E:
  - 000 Zero; 001 !Zero
  - 100 Lt; 101 !Lt
  - 110 Ltu; 111 !Ltu
  - 010/011 never taken; o_IllegalBranchE=1
- o_PCSrcE = ValidE & !i_StallE & (JumpE | JalrE | (BranchE & cond)).
- o_PCTargetSelE = JalrE & ValidE.
- JumpE and JalrE both set: treated as JALR.
- The flushes triggered by a redirect are the hazard unit's job. This block applies whatever i_FlushE it is given.

## Timing
- Latency D->E 1 cycle; E->M1 1 cycle; each extra M stage +1; D->W = 2 + MEM_STAGES cycles.
- o_PCSrcE, o_PCTargetSelE, o_IllegalBranchE and o_ResultSrcE_0 are combinational from E-register contents and the same-cycle ALU flags and i_StallE.
- On the clock edge with i_Reset=1, every stage register, valid bit and counter clears. This holds regardless of i_StallE or i_FlushE. All outputs are 0 the cycle after.
- i_FlushE and i_StallE both high: flush wins; E becomes a bubble and M1 receives a bubble.
- Stall held N cycles: o_PCSrcE stays 0 for N cycles. It asserts in the first unstalled cycle if the condition holds.
- Stall on an E bubble: E stays a bubble, with no side effects.

## Configuration
- Macro CTRL_PIPE_PERF_EN.
- Defined:
  - o_RetiredCount increments on every cycle with ValidW=1.
  - o_RedirectCount increments on every cycle with o_PCSrcE=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on i_Reset.
- Undefined: no counter flops are built; both ports are tied to 0. The port list is unchanged.

## Test plan
- Reset mid-stream:
  - Stimulus: valid ALU ops flowing; pulse i_Reset=1 for 1 cycle.
  - Response: next cycle all outputs 0; o_ValidW=0 for 2+MEM_STAGES cycles after restart.
- Branch matrix:
  - Stimulus: for each funct3 in {000,001,100,101,110,111} × flag combinations, with BranchD=1.
  - Response: o_PCSrcE matches the table. funct3=010 gives o_PCSrcE=0 and o_IllegalBranchE=1.
- Stall/flush:
  - Stimulus: taken BEQ in E with i_StallE=1 for 3 cycles.
  - Response: o_PCSrcE=0 for 3 cycles, then 1. M1 shows bubbles (o_RegWriteM=0) during the stall.
  - Stimulus: i_FlushE=1 with i_StallE=1. Response: E is a bubble next cycle.
- Latency with MEM_STAGES=3:
  - Stimulus: a load issued at cycle t.
  - Response: o_LoadPendingM=1 at cycles t+2..t+4; o_RegWriteW=1 and o_ResultSrcW=01 at t+5.
- JALR:
  - Stimulus: JalrD=1 and JumpD=1.
  - Response: one cycle later o_PCSrcE=1 and o_PCTargetSelE=1.
- Counters (CTRL_PIPE_PERF_EN):
  - Stimulus: 10 valid instructions including 2 taken branches.
  - Response: o_RetiredCount=10 and o_RedirectCount=2. Forcing a counter to 0xFFFFFFFF wraps it to 0 on the next increment.
